// File: rtl/encode_fifo.sv
// rtl/encode_fifo.sv - registered 4-to-2 priority encoder with valid/ready FIFO buffering
//
// Purpose: encodes one-hot lines d0..d3 (d3 highest priority) into {a,b} and
// queues each non-zero sample in a DEPTH-entry FIFO. All-zero samples are
// accepted but not stored; they bump a saturating drop counter instead.
//
// Optional feature macro: ENCODE_ONEHOT_CHECK_EN
//   defined   : entries carry an err bit set for multi-hot samples
//   undefined : err is tied to 0 and entries hold {a,b} only
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   d0..d3     in   sample lines
//   in_valid   in   sample present on d0..d3
//   in_ready   out  a sample can be accepted this cycle
//   a, b       out  encoded index at the FIFO head (0 when empty)
//   err        out  head entry came from a multi-hot sample (0 when empty)
//   out_valid  out  FIFO head holds an entry
//   out_ready  in   consumer takes the head entry this cycle
//   drop_cnt   out  saturating count of accepted all-zero samples

module encode_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d0,
    input  logic             d1,
    input  logic             d2,
    input  logic             d3,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             a,
    output logic             b,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef ENCODE_ONEHOT_CHECK_EN
    localparam int EW = 3;
`else
    localparam int EW = 2;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          any_set;
    logic          accept;
    logic          push;
    logic          pop;
    logic [1:0]    code;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    always_comb begin
        code = 2'b00;
        if (d3)      code = 2'b11;
        else if (d2) code = 2'b10;
        else if (d1) code = 2'b01;
    end

    assign any_set = d0 | d1 | d2 | d3;

`ifdef ENCODE_ONEHOT_CHECK_EN
    logic multi_hot;
    assign multi_hot = (3'(d0) + 3'(d1) + 3'(d2) + 3'(d3)) >= 3'd2;
    assign wr_entry  = {code, multi_hot};
`else
    assign wr_entry  = code;
`endif

    // in_ready looks only at the count, so out_ready never reaches it combinationally.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign push      = accept & any_set;
    assign pop       = out_valid & out_ready;

    // Head is read combinationally; masking with out_valid forces zeros when empty.
    assign head = mem[rd_ptr];
    assign a    = out_valid & head[EW-1];
    assign b    = out_valid & head[EW-2];
`ifdef ENCODE_ONEHOT_CHECK_EN
    assign err  = out_valid & head[0];
`else
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (accept && !any_set && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // Storage needs no reset: nothing is visible until count says it is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

endmodule
